pc_sequencer: RTL
=================

# pc_sequencer

Multi-cycle program-counter sequencer for the 32-bit processor. Owns the PC register and steps the core through fetch, decode, execute and PC-update phases. It runs the instruction-memory request/acknowledge handshake, resolves conditional branches from `reg2_data`, and handles halt/resume. It sits between instruction memory and the execute datapath and replaces free-running per-clock PC updates with an explicit state machine.

## Interface
Parameters:
- `RESET_PC`, default 32'h0: PC value loaded on reset.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; leaves IDLE.
- `resume`  in  1  leaves HALTED.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_ack`  in  1  memory acknowledge; `imem_rdata` valid the same cycle.
- `imem_rdata`  in  32  fetched instruction.
- `instr`  out  32  latched current instruction.
- `instr_valid`  out  1  one-cycle pulse in DECODE.
- `exec_done`  in  1  datapath has finished the current instruction.
- `branch_op`  in  3  branch code: 001 always, 011 if <0, 101 if >0, 111 if ==0.
- `reg2_data`  in  32  signed branch test operand.
- `branch_target`  in  32  ALU-computed target.
- `halt_op`  in  1  current instruction is HALT.
- `pc`  out  32  program counter.
- `halted`  out  1  high in HALTED.
- `state`  out  3  encoded FSM state.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, HALTED=4. Codes 5–7 are unreachable and go to IDLE.
- IDLE: `start` → FETCH.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`, held until `imem_ack`. On ack, `instr` ← `imem_rdata` and the FSM goes to DECODE.
- DECODE: one cycle with `instr_valid`=1, then EXECUTE.
- EXECUTE: wait for `exec_done`. On the `exec_done` cycle, sample `halt_op`, `branch_op`, `reg2_data` and `branch_target`:
  - `halt_op`=1: `pc` unchanged, go to HALTED. Halt wins over any branch.
  - Branch taken: `pc` ← `branch_target`, go to FETCH.
  - Otherwise: `pc` ← `pc`+1, go to FETCH.
- Branch comparisons are signed 32-bit. Codes 000, 010, 100 and 110 are never taken.
- HALTED: `resume` → `pc` ← `pc`+1, go to FETCH.
- `pc`+1 is modulo 2^32: 32'hFFFFFFFF wraps to 0.
- `start` outside IDLE is ignored. `imem_ack` outside FETCH is ignored. `exec_done` outside EXECUTE is ignored.

## Timing
- Reset values: `pc`=`RESET_PC`, `state`=IDLE, `instr`=0, and `imem_req`, `instr_valid`, `halted` = 0.
- Reset asserted in any state takes effect at the next edge. An outstanding fetch is abandoned (`imem_req` drops) and no PC update occurs.
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.
- Minimum instruction latency with zero-wait memory (ack in the first FETCH cycle) and `exec_done` in the first EXECUTE cycle is 3 cycles (FETCH, DECODE, EXECUTE).
- A new `pc` is visible on `imem_addr` in the FETCH cycle directly after EXECUTE.
- `imem_addr` is stable throughout a FETCH wait.

## Configuration
- `PC_SEQ_PERF_CNT_EN`, when defined, adds:
  - output `retired_cnt` [31:0]: incremented on each `exec_done` accepted in EXECUTE, including halt.
  - output `taken_cnt` [15:0]: incremented on each taken branch; saturates at 16'hFFFF.
  - Both counters clear on reset.
- When undefined, neither port nor counter exists and the behaviour is otherwise identical.

## Test plan
- Reset, then `start`; memory acks after 2 wait cycles → `imem_req` high for 3 cycles with `imem_addr`=0, `instr_valid` pulses once, and after `exec_done` with `branch_op`=000 the next fetch is at `pc`=1.
- `branch_op`=011 with `reg2_data`=-5 and target 40 → `pc`=40. Repeat with `reg2_data`=0 → `pc`=old+1.
- `branch_op`=111 with `reg2_data`=0, then 101 with `reg2_data`=7, then 101 with `reg2_data`=-1 → taken, taken, not taken.
- `halt_op`=1 together with `branch_op`=001 at `pc`=9 → HALTED, `halted`=1, `pc`=9. `resume` → FETCH at `pc`=10.
- `pc`=32'hFFFFFFFF with a non-branch → next fetch at 0. Reset asserted mid-FETCH → the next cycle is IDLE with `imem_req`=0 and `pc`=`RESET_PC`.
- With `PC_SEQ_PERF_CNT_EN`: run 5 instructions, 2 of them taken branches → `retired_cnt`=5, `taken_cnt`=2.

Source files
------------

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: FETCH/DECODE/EXECUTE stepping with imem handshake,
// branch resolution and halt/resume. Optional counters under PC_SEQ_PERF_CNT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        resume,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [2:0]  branch_op,
  input  logic [31:0] reg2_data,
  input  logic [31:0] branch_target,
  input  logic        halt_op,
  output logic [31:0] pc,
  output logic        halted,
  output logic [2:0]  state
`ifdef PC_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [15:0] taken_cnt
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXECUTE = 3'd3;
  localparam logic [2:0] S_HALTED  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        br_taken;

  // Signed tests reduce to sign bit and zero detect.
  always_comb begin
    br_taken = 1'b0;
    case (branch_op)
      3'b001:  br_taken = 1'b1;
      3'b011:  br_taken = reg2_data[31];
      3'b101:  br_taken = !reg2_data[31] && (reg2_data != '0);
      3'b111:  br_taken = (reg2_data == '0);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (exec_done) begin
          if (halt_op) begin
            state_d = S_HALTED;
          end else if (br_taken) begin
            pc_d    = branch_target;
            state_d = S_FETCH;
          end else begin
            pc_d    = pc_q + 32'd1;
            state_d = S_FETCH;
          end
        end
      end
      S_HALTED: begin
        if (resume) begin
          pc_d    = pc_q + 32'd1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_DECODE);
  assign pc          = pc_q;
  assign halted      = (state_q == S_HALTED);
  assign state       = state_q;

`ifdef PC_SEQ_PERF_CNT_EN
  logic [31:0] retired_q;
  logic [15:0] taken_q;
  logic        retire_evt;
  logic        taken_evt;

  assign retire_evt = (state_q == S_EXECUTE) && exec_done;
  assign taken_evt  = retire_evt && !halt_op && br_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
      taken_q   <= '0;
    end else begin
      if (retire_evt) retired_q <= retired_q + 32'd1;
      if (taken_evt && (taken_q != '1)) taken_q <= taken_q + 16'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign taken_cnt   = taken_q;
`endif

endmodule
